// File: rtl/sprite_blit_pkg.sv
// Shared types and defaults for the sprite blitter.
// SPRITE_BLIT_TRANSPARENT_EN enables the color-key drop in sprite_blit.
package sprite_blit_pkg;

   localparam int FB_W_DEF = 640;
   localparam int FB_H_DEF = 480;

   typedef logic [11:0] color_t;

   localparam color_t TRANSPARENT_COLOR = 12'hF0F;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_t;

   typedef struct packed {
      logic        valid;
      logic        clip;
      logic [18:0] addr;
   } s1_t;

   typedef struct packed {
      logic        valid;
      logic [18:0] addr;
      color_t      data;
   } s2_t;

endpackage

// File: rtl/sprite_blit_addr_gen.sv
// Sprite scan counters plus ROM and framebuffer address products.
// Also flags pixels that fall outside the framebuffer.
module blit_addr_gen
   import sprite_blit_pkg::*;
#(
   parameter int SPR_W = 52,
   parameter int SPR_H = 321,
   parameter int FB_W  = FB_W_DEF,
   parameter int FB_H  = FB_H_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        adv,
   input  logic [9:0]  dx,
   input  logic [8:0]  dy,
   output logic [14:0] rom_addr,
   output logic [18:0] fb_addr,
   output logic        clip,
   output logic        last
);

   logic [9:0]  sx;
   logic [8:0]  sy;
   logic [10:0] col;
   logic [9:0]  row;
   logic        row_end;

   assign row_end = (sx == 10'(SPR_W - 1));
   assign last    = row_end && (sy == 9'(SPR_H - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sx <= '0;
         sy <= '0;
      end else if (adv) begin
         if (last) begin
            sx <= '0;
            sy <= '0;
         end else if (row_end) begin
            sx <= '0;
            sy <= sy + 9'd1;
         end else begin
            sx <= sx + 10'd1;
         end
      end
   end

   // widened sums so a sprite hanging off the edge never wraps back in
   assign col = {1'b0, dx} + {1'b0, sx};
   assign row = {1'b0, dy} + {1'b0, sy};

   assign clip     = (col >= 11'(FB_W)) || (row >= 10'(FB_H));
   assign rom_addr = 15'(sx) + 15'(sy) * 15'(SPR_W);
   assign fb_addr  = 19'(row) * 19'(FB_W) + 19'(col);

endmodule

// File: rtl/sprite_blit.sv
// Sprite blitter: ROM read pipeline with stall skid and clipping.
// SPRITE_BLIT_TRANSPARENT_EN drops pixels equal to TRANSPARENT_COLOR.
module sprite_blit
   import sprite_blit_pkg::*;
#(
   parameter int SPR_W = 52,
   parameter int SPR_H = 321,
   parameter int FB_W  = FB_W_DEF,
   parameter int FB_H  = FB_H_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [9:0]  dst_x,
   input  logic [8:0]  dst_y,
   output logic [14:0] rom_addr,
   input  logic [11:0] rom_data,
   output logic        fb_we,
   output logic [18:0] fb_addr,
   output logic [11:0] fb_data,
   input  logic        fb_ready,
   output logic        busy,
   output logic        done
);

   state_t      state;
   logic [9:0]  dx;
   logic [8:0]  dy;
   s1_t         s1;
   s2_t         s2;
   s2_t         skid;
   logic [18:0] pix_addr;
   logic        clip;
   logic        last;
   logic        stall;
   logic        issue;
   logic        live;

   assign stall = s2.valid && !fb_ready;
   assign issue = (state == RUN) && !stall;

`ifdef SPRITE_BLIT_TRANSPARENT_EN
   assign live = s1.valid && !s1.clip && (rom_data != TRANSPARENT_COLOR);
`else
   assign live = s1.valid && !s1.clip;
`endif

   blit_addr_gen #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .FB_W  (FB_W),
      .FB_H  (FB_H)
   ) u_addr (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == IDLE && start),
      .adv      (issue),
      .dx       (dx),
      .dy       (dy),
      .rom_addr (rom_addr),
      .fb_addr  (pix_addr),
      .clip     (clip),
      .last     (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         dx    <= '0;
         dy    <= '0;
         s1    <= '0;
         s2    <= '0;
         skid  <= '0;
      end else begin
         done     <= 1'b0;
         s1.valid <= issue;
         if (issue) begin
            s1.clip <= clip;
            s1.addr <= pix_addr;
         end
         // the word returning in the first stall cycle parks in skid
         if (!stall) begin
            if (skid.valid) begin
               s2         <= skid;
               skid.valid <= 1'b0;
            end else if (live) begin
               s2 <= '{valid: 1'b1, addr: s1.addr, data: rom_data};
            end else begin
               s2.valid <= 1'b0;
            end
         end else if (live) begin
            skid <= '{valid: 1'b1, addr: s1.addr, data: rom_data};
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  dx    <= dst_x;
                  dy    <= dst_y;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (issue && last) state <= DRAIN;
            end
            DRAIN: begin
               if (!s1.valid && !skid.valid && !stall) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end
            end
            FIN: state <= IDLE;
         endcase
      end
   end

   assign fb_we   = s2.valid;
   assign fb_addr = s2.addr;
   assign fb_data = s2.data;

endmodule

// File: tb/tb_sprite_blit.sv
// Randomized bench for sprite_blit against a per-pixel reference model.
// Build with SPRITE_BLIT_TRANSPARENT_EN to check the color-key variant.
module tb_sprite_blit;

   localparam int SW   = 52;
   localparam int SH   = 321;
   localparam int FW   = 640;
   localparam int FH   = 480;
   localparam int NPIX = SW * SH;

`ifdef SPRITE_BLIT_TRANSPARENT_EN
   localparam int TR = 1;
`else
   localparam int TR = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  dst_x;
   logic [8:0]  dst_y;
   logic [14:0] rom_addr;
   logic [11:0] rom_data;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [11:0] fb_data;
   logic        fb_ready;
   logic        busy;
   logic        done;

   sprite_blit #(
      .SPR_W (SW),
      .SPR_H (SH),
      .FB_W  (FW),
      .FB_H  (FH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dst_x    (dst_x),
      .dst_y    (dst_y),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .fb_we    (fb_we),
      .fb_addr  (fb_addr),
      .fb_data  (fb_data),
      .fb_ready (fb_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   logic [11:0] rom [NPIX];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      fb_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input longint got,
                        input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [30:0] exp_q[$];
   int nwr, nbad, ndone, nstall_bad, maxcol;
   int first_addr, first_cyc, last_cyc, done_cyc;
   logic        prev_hold;
   logic [18:0] paddr;
   logic [11:0] pdata;

   task automatic clr_mon();
      nwr = 0; nbad = 0; ndone = 0; nstall_bad = 0; maxcol = 0;
      first_addr = -1; first_cyc = 0; last_cyc = 0; done_cyc = 0;
   endtask

   // expected write stream computed straight from the pixel rules
   task automatic build_exp(input int dx, input int dy);
      exp_q.delete();
      for (int y = 0; y < SH; y++)
         for (int x = 0; x < SW; x++) begin
            int col = dx + x;
            int row = dy + y;
            logic [11:0] c = rom[x + y * SW];
            bit keep = (col < FW) && (row < FH);
            if (TR == 1 && c == 12'hF0F) keep = 0;
            if (keep) exp_q.push_back({19'(row * FW + col), c});
         end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (done) begin ndone++; done_cyc = cyc; end
         if (prev_hold && !(fb_we === 1'b1 && fb_addr == paddr &&
                            fb_data == pdata))
            nstall_bad++;
         prev_hold = fb_we && !fb_ready;
         paddr = fb_addr;
         pdata = fb_data;
         if (fb_we && fb_ready) begin
            if (nwr == 0) begin first_addr = fb_addr; first_cyc = cyc; end
            if (int'(fb_addr % 640) > maxcol) maxcol = int'(fb_addr % 640);
            if (exp_q.size() == 0) nbad++;
            else begin
               if (exp_q[0] != {fb_addr, fb_data}) nbad++;
               void'(exp_q.pop_front());
            end
            nwr++;
            last_cyc = cyc;
         end
      end
   end

   task automatic pulse_start(input int dx, input int dy);
      @(posedge clk); #1;
      dst_x = 10'(dx); dst_y = 9'(dy); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_blit(input string tag, input int dx, input int dy,
                           input int mode, input bit extra,
                           input bit lat, input int exp_n,
                           input int exp_first);
      int to = 0;
      build_exp(dx, dy);
      clr_mon();
      rdy_mode = mode;
      pulse_start(dx, dy);
      check({tag, "_busy_on"}, busy, 1);
      if (extra) begin
         repeat (50) @(posedge clk);
         pulse_start(0, 0);
      end
      while (ndone == 0 && to < 50000) begin
         @(posedge clk);
         to++;
      end
      check({tag, "_done_seen"}, ndone > 0, 1);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_writes"}, nwr, exp_n);
      check({tag, "_data_bad"}, nbad, 0);
      check({tag, "_left"}, exp_q.size(), 0);
      check({tag, "_first_addr"}, first_addr, exp_first);
      check({tag, "_ndone"}, ndone, 1);
      check({tag, "_stall_hold"}, nstall_bad, 0);
      check({tag, "_busy_off"}, busy, 0);
      check({tag, "_maxcol_ok"}, maxcol < FW, 1);
      if (lat) check({tag, "_done_lat"}, done_cyc - last_cyc, 1);
   endtask

   initial begin
      int to, c0, rx, ry;
      for (int i = 0; i < NPIX; i++) begin
         logic [11:0] v = 12'($urandom);
         rom[i] = (v == 12'hF0F) ? 12'h000 : v;
      end
      rom[0] = 12'hF0F;
      rst = 1'b1; start = 1'b0; dst_x = '0; dst_y = '0;
      clr_mon();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we", fb_we, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_data", fb_data, 0);
      rst = 1'b0;

      run_blit("full", 100, 50, 0, 1'b1, 1'b1, NPIX - TR, 32100 + TR);
      run_blit("clip", 600, 0, 0, 1'b0, 1'b0, 40 * SH - TR, 600 + TR);
      run_blit("stall", 100, 50, 1, 1'b0, 1'b1, NPIX - TR, 32100 + TR);

      build_exp(100, 50);
      clr_mon();
      rdy_mode = 0;
      pulse_start(100, 50);
      to = 0;
      while (nwr < 1000 && to < 5000) begin
         @(posedge clk);
         to++;
      end
      check("abort_reach", nwr >= 1000, 1);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_we", fb_we, 0);
      check("abort_done", done, 0);
      check("abort_rom_addr", rom_addr, 0);
      check("abort_fb_addr", fb_addr, 0);
      rst = 1'b0;

      rx = $urandom_range(0, 500);
      ry = $urandom_range(0, 150);
      build_exp(rx, ry);
      clr_mon();
      @(posedge clk); #1;
      dst_x = 10'(rx); dst_y = 9'(ry); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c0 = cyc;
      to = 0;
      while (nwr < 4 && to < 50) begin
         @(posedge clk);
         to++;
      end
      #1;
      check("restart_writes", nwr >= 4, 1);
      check("restart_first", first_addr, ry * FW + rx + TR);
      check("restart_lat", first_cyc - c0, 2 + TR);
      check("restart_data_bad", nbad, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("restart_abort_busy", busy, 0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
